// File: rtl/riscv_pkg.sv
// Shared types and defaults for the EX/MEM stage and its squash controller.
package riscv_pkg;

  localparam int DATA_WIDTH_D = 32;
  localparam int REG_ADDR_W_D = 5;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
  } ctrl_t;

  typedef enum logic {
    RUN,
    SQUASH
  } ex_state_t;

  // The ALU reports the branch condition outcome in bit 0 of its result.
  function automatic logic is_taken(input ctrl_t c, input logic cond);
    return c.jump || (c.branch && cond);
  endfunction

endpackage

// File: rtl/ex_mem_stage_squash_ctrl.sv
// Redirect/squash controller: emits a one-cycle redirect on a taken accept and
// then discards a fixed number of accepted wrong-path slots.
module squash_ctrl
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_D,
  parameter int SQUASH_SLOTS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  accept,
  input  logic                  taken,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] target,
  output logic                  squashing,
  output logic                  redirect,
  output logic [DATA_WIDTH-1:0] redirect_pc
);

  ex_state_t  state_reg;
  logic [2:0] cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= RUN;
      cnt_reg     <= '0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      // A pulse already on the output always drops after its single cycle.
      redirect <= 1'b0;
      if (flush) begin
        state_reg <= RUN;
        cnt_reg   <= '0;
      end else if (accept) begin
        case (state_reg)
          RUN: begin
            if (taken) begin
              state_reg   <= SQUASH;
              cnt_reg     <= 3'(SQUASH_SLOTS);
              redirect    <= 1'b1;
              redirect_pc <= target;
            end
          end
          SQUASH: begin
            cnt_reg <= cnt_reg - 3'd1;
            if (cnt_reg == 3'd1) state_reg <= RUN;
          end
          default: state_reg <= RUN;
        endcase
      end
    end
  end

  assign squashing = (state_reg == SQUASH);

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch resolution and wrong-path squashing.
// Optional MEM->EX forwarding outputs are enabled by defining FWD_BYPASS_EN.
module ex_mem_stage
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_D,
  parameter int REG_ADDR_W   = REG_ADDR_W_D,
  parameter int SQUASH_SLOTS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] ex_store_data,
  input  logic [DATA_WIDTH-1:0] ex_branch_target,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  ctrl_t                 ex_ctrl,
  input  logic                  flush,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] mem_alu_result,
  output logic [DATA_WIDTH-1:0] mem_store_data,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output ctrl_t                 mem_ctrl,
  output logic                  redirect,
  output logic [DATA_WIDTH-1:0] redirect_pc
`ifdef FWD_BYPASS_EN
  ,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [DATA_WIDTH-1:0] fwd_data
`endif
);

  logic accept;
  logic taken;
  logic squashing;

  assign ex_ready = !mem_valid || mem_ready;
  assign accept   = ex_valid && ex_ready;
  assign taken    = is_taken(ex_ctrl, ALUResult[0]);

  squash_ctrl #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SQUASH_SLOTS(SQUASH_SLOTS)
  ) u_squash (
    .clk        (clk),
    .reset      (reset),
    .accept     (accept),
    .taken      (taken),
    .flush      (flush),
    .target     (ex_branch_target),
    .squashing  (squashing),
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
  );

  // Squashed slots are still captured so the payload registers never need a
  // separate enable path; only the valid bit is suppressed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid      <= 1'b0;
      mem_alu_result <= '0;
      mem_store_data <= '0;
      mem_rd         <= '0;
      mem_ctrl       <= '0;
    end else if (flush) begin
      mem_valid <= 1'b0;
    end else if (accept) begin
      mem_valid      <= !squashing;
      mem_alu_result <= ALUResult;
      mem_store_data <= ex_store_data;
      mem_rd         <= ex_rd;
      mem_ctrl       <= ex_ctrl;
    end else if (mem_ready) begin
      mem_valid <= 1'b0;
    end
  end

`ifdef FWD_BYPASS_EN
  // x0 is hard-wired to zero, so it is never a forwarding source.
  assign fwd_valid = mem_valid && mem_ctrl.reg_write && !mem_ctrl.mem_read &&
                     (mem_rd != '0);
  assign fwd_rd    = mem_rd;
  assign fwd_data  = mem_alu_result;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: stimulus predicts MEM entries and
// redirect targets, a negedge monitor pops and compares them.
module tb_ex_mem_stage;
  import riscv_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int SLOTS = 2;

  localparam logic [4:0] C_ALU = 5'b10000;
  localparam logic [4:0] C_ST  = 5'b00100;
  localparam logic [4:0] C_BR  = 5'b00010;
  localparam logic [4:0] C_JAL = 5'b10001;

  typedef struct {
    logic [DW-1:0] alu;
    logic [DW-1:0] sd;
    logic [AW-1:0] rd;
    logic [4:0]    ctrl;
  } entry_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          ex_valid;
  logic          ex_ready;
  logic [DW-1:0] alu_result;
  logic [DW-1:0] ex_store_data;
  logic [DW-1:0] ex_branch_target;
  logic [AW-1:0] ex_rd;
  ctrl_t         ex_ctrl;
  logic          flush;
  logic          mem_valid;
  logic          mem_ready;
  logic [DW-1:0] mem_alu_result;
  logic [DW-1:0] mem_store_data;
  logic [AW-1:0] mem_rd;
  ctrl_t         mem_ctrl;
  logic          redirect;
  logic [DW-1:0] redirect_pc;
`ifdef FWD_BYPASS_EN
  logic          fwd_valid;
  logic [AW-1:0] fwd_rd;
  logic [DW-1:0] fwd_data;
`endif

  ex_mem_stage #(.DATA_WIDTH(DW), .REG_ADDR_W(AW), .SQUASH_SLOTS(SLOTS)) u_dut (
    .clk             (clk),
    .reset           (reset),
    .ex_valid        (ex_valid),
    .ex_ready        (ex_ready),
    .ALUResult       (alu_result),
    .ex_store_data   (ex_store_data),
    .ex_branch_target(ex_branch_target),
    .ex_rd           (ex_rd),
    .ex_ctrl         (ex_ctrl),
    .flush           (flush),
    .mem_valid       (mem_valid),
    .mem_ready       (mem_ready),
    .mem_alu_result  (mem_alu_result),
    .mem_store_data  (mem_store_data),
    .mem_rd          (mem_rd),
    .mem_ctrl        (mem_ctrl),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc)
`ifdef FWD_BYPASS_EN
    ,
    .fwd_valid       (fwd_valid),
    .fwd_rd          (fwd_rd),
    .fwd_data        (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  entry_t        exp_q[$];
  logic [DW-1:0] redir_q[$];
  int            squash_left = 0;
  int            checks = 0;
  int            failures = 0;
  logic          done = 1'b0;

  // Presents one instruction, waits for acceptance, then updates the model.
  task automatic send(input logic [DW-1:0] alu, input logic [DW-1:0] sd,
                      input logic [DW-1:0] tgt, input logic [AW-1:0] rd,
                      input logic [4:0] c, input logic fl);
    int     n;
    entry_t e;
    logic   tk;
    ex_valid = 1'b1;
    alu_result = alu;
    ex_store_data = sd;
    ex_branch_target = tgt;
    ex_rd = rd;
    ex_ctrl = ctrl_t'(c);
    flush = fl;
    n = 0;
    @(negedge clk);
    while (!ex_ready) begin
      n++;
      if (n > 100) begin
        $display("FAIL send_timeout ex_ready=%b required 1 within 100 cycles", ex_ready);
        $fatal(1);
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    flush = 1'b0;
    tk = c[0] || (c[1] && alu[0]);
    if (fl) begin
      squash_left = 0;
    end else if (squash_left > 0) begin
      squash_left--;
    end else begin
      e.alu = alu; e.sd = sd; e.rd = rd; e.ctrl = c;
      exp_q.push_back(e);
      if (tk) begin
        redir_q.push_back(tgt);
        squash_left = SLOTS;
      end
    end
    $display("send alu=%h rd=%0d ctrl=%b flush=%b queued=%0d", alu, rd, c, fl, exp_q.size());
  endtask

  // Monitor / checker
  initial begin
    logic          prev_hold;
    logic          prev_redir;
    logic [2*DW+AW+4:0] snap;
    entry_t        e;
    logic [DW-1:0] pc;
    prev_hold = 1'b0;
    prev_redir = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        checks++;
        if (mem_valid !== 1'b0 || redirect !== 1'b0 || mem_alu_result !== '0 || redirect_pc !== '0) begin
          failures++;
          $display("FAIL reset_state mem_valid=%b redirect=%b alu=%h pc=%h required all zero",
                   mem_valid, redirect, mem_alu_result, redirect_pc);
        end
        prev_hold = 1'b0;
        prev_redir = 1'b0;
      end else begin
        checks++;
        if (ex_ready !== (!mem_valid || mem_ready)) begin
          failures++;
          $display("FAIL ex_ready got=%b required=%b", ex_ready, !mem_valid || mem_ready);
        end
        if (prev_hold) begin
          checks++;
          if ({mem_alu_result, mem_store_data, mem_rd, mem_ctrl} !== snap || mem_valid !== 1'b1) begin
            failures++;
            $display("FAIL hold_stable got=%h valid=%b required=%h valid=1",
                     {mem_alu_result, mem_store_data, mem_rd, mem_ctrl}, mem_valid, snap);
          end
        end
        if (mem_valid && mem_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL mem_unexpected got alu=%h rd=%0d required no valid entry", mem_alu_result, mem_rd);
          end else begin
            e = exp_q.pop_front();
            if (mem_alu_result !== e.alu || mem_store_data !== e.sd || mem_rd !== e.rd || mem_ctrl !== ctrl_t'(e.ctrl)) begin
              failures++;
              $display("FAIL mem_entry got alu=%h sd=%h rd=%0d ctrl=%b required alu=%h sd=%h rd=%0d ctrl=%b",
                       mem_alu_result, mem_store_data, mem_rd, mem_ctrl, e.alu, e.sd, e.rd, e.ctrl);
            end else begin
              $display("mem alu=%h rd=%0d ctrl=%b ok", mem_alu_result, mem_rd, mem_ctrl);
            end
          end
        end
        if (redirect) begin
          checks++;
          if (prev_redir) begin
            failures++;
            $display("FAIL redirect_width got=2+ cycles required=1 cycle");
          end
          checks++;
          if (redir_q.size() == 0) begin
            failures++;
            $display("FAIL redirect_unexpected got pc=%h required no redirect", redirect_pc);
          end else begin
            pc = redir_q.pop_front();
            if (redirect_pc !== pc) begin
              failures++;
              $display("FAIL redirect_pc got=%h required=%h", redirect_pc, pc);
            end else begin
              $display("redirect pc=%h ok", redirect_pc);
            end
          end
        end
`ifdef FWD_BYPASS_EN
        checks++;
        if (fwd_valid !== (mem_valid && mem_ctrl.reg_write && !mem_ctrl.mem_read && mem_rd != '0) ||
            fwd_rd !== mem_rd || fwd_data !== mem_alu_result) begin
          failures++;
          $display("FAIL fwd got valid=%b rd=%0d data=%h required valid=%b rd=%0d data=%h",
                   fwd_valid, fwd_rd, fwd_data,
                   mem_valid && mem_ctrl.reg_write && !mem_ctrl.mem_read && mem_rd != '0,
                   mem_rd, mem_alu_result);
        end
`endif
        prev_hold = mem_valid && !mem_ready;
        snap = {mem_alu_result, mem_store_data, mem_rd, mem_ctrl};
        prev_redir = redirect;
      end
      if (done) begin
        checks++;
        if (exp_q.size() != 0) begin
          failures++;
          $display("FAIL mem_missing got=%0d pending entries required=0", exp_q.size());
        end
        checks++;
        if (redir_q.size() != 0) begin
          failures++;
          $display("FAIL redirect_missing got=%0d pending redirects required=0", redir_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  // Stimulus
  initial begin
    reset = 1'b1;
    ex_valid = 1'b0;
    alu_result = '0;
    ex_store_data = '0;
    ex_branch_target = '0;
    ex_rd = '0;
    ex_ctrl = '0;
    flush = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // ADD passthrough
    send(32'h0000_0015, 32'h0, 32'h0, 5'd5, C_ALU, 1'b0);

    // MEM stall for 3 cycles while EX holds the next instruction
    mem_ready = 1'b0;
    fork
      send(32'h0000_0022, 32'h0, 32'h0, 5'd7, C_ALU, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1 mem_ready = 1'b1;
      end
    join

    // Store
    send(32'h0000_0080, 32'hDEAD_BEEF, 32'h0, 5'd0, C_ST, 1'b0);

    // Taken BNE then three followers: two squashed, third valid
    send(32'h0000_0001, 32'h0, 32'h0000_0040, 5'd0, C_BR, 1'b0);
    send(32'h0000_0A01, 32'h0, 32'h0, 5'd8, C_ALU, 1'b0);
    send(32'h0000_0A02, 32'h0, 32'h0, 5'd9, C_BR, 1'b0);
    send(32'h0000_0A03, 32'h0, 32'h0, 5'd10, C_ALU, 1'b0);

    // Not-taken BEQ stays in RUN
    send(32'h0000_0000, 32'h0, 32'h0000_0080, 5'd0, C_BR, 1'b0);
    send(32'h0000_0B01, 32'h0, 32'h0, 5'd11, C_ALU, 1'b0);

    // JAL with MEM stalled during the redirect cycle
    send(32'h0000_0104, 32'h0, 32'h0000_0200, 5'd1, C_JAL, 1'b0);
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 mem_ready = 1'b1;
    send(32'h0000_0C01, 32'h0, 32'h0, 5'd12, C_ALU, 1'b0);
    send(32'h0000_0C02, 32'h0, 32'h0, 5'd13, C_ALU, 1'b0);
    send(32'h0000_0C03, 32'h0, 32'h0, 5'd14, C_ALU, 1'b0);

    // Write to x0 (never forwarded), then flush beating a taken branch
    send(32'h0000_0009, 32'h0, 32'h0, 5'd0, C_ALU, 1'b0);
    send(32'h0000_0001, 32'h0, 32'h0000_0300, 5'd0, C_BR, 1'b1);
    // A taken jump right after the flush proves the FSM is back in RUN
    send(32'h0000_0308, 32'h0, 32'h0000_0400, 5'd1, C_JAL, 1'b0);
    // Flush mid-squash clears the remaining count
    send(32'h0000_0077, 32'h0, 32'h0, 5'd3, C_ALU, 1'b1);
    send(32'h0000_0088, 32'h0, 32'h0, 5'd4, C_ALU, 1'b0);

    // Reset while in SQUASH with a held MEM entry
    send(32'h0000_0001, 32'h0, 32'h0000_0500, 5'd0, C_BR, 1'b0);
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    redir_q.delete();
    squash_left = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    mem_ready = 1'b1;
    send(32'h0000_0D01, 32'h0, 32'h0, 5'd15, C_ALU, 1'b0);
    send(32'h0000_0D02, 32'h0, 32'h0000_0600, 5'd1, C_JAL, 1'b0);
    send(32'h0000_0D03, 32'h0, 32'h0, 5'd16, C_ALU, 1'b0);
    send(32'h0000_0D04, 32'h0, 32'h0, 5'd17, C_ALU, 1'b0);
    send(32'h0000_0D05, 32'h0, 32'h0, 5'd18, C_ALU, 1'b0);

    repeat (4) @(posedge clk);
    #1 done = 1'b1;
  end

endmodule
